// File: rtl/spiflash4x_target.sv
// QSPI flash responder: oversamples the spiflash4x bus on clk and serves 0x03, 0xEB and 0x9F
// from a byte-wide fetch port with a one-byte prefetch buffer.
module spiflash4x_target #(
    parameter int          ADDR_W     = 24,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
    parameter int          DUMMY_QUAD = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic [3:0]        spi_dq_i,
    output logic [3:0]        spi_dq_o,
    output logic [3:0]        spi_dq_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              underrun
);
    // state  | meaning
    // IDLE   | CS high;  CMD | opcode shift;  ADDR | address shift;  MODE | mode byte (0xEB)
    // DUMMY  | turnaround; DATA | memory bytes out;  ID | JEDEC bytes then 0xFF;  IGNORE | unknown opcode
    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, ID, IGNORE} state_t;

    logic [2:0]        sclk_q, cs_q;
    logic [3:0]        dq_meta_q, dq_sync_q;
    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [23:0]       sh_q, sh_d, sh_next;
    logic              quad_q, quad_d;
    logic [7:0]        out_sh_q, out_sh_d;
    logic [2:0]        out_cnt_q, out_cnt_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic [ADDR_W-1:0] need_q, need_d, mem_addr_q, mem_addr_d;
    logic [7:0]        buf_q, buf_d;
    logic              buf_v_q, buf_v_d, mem_req_q, mem_req_d, underrun_q, underrun_d;
    logic [3:0]        dq_o_q, dq_o_d, dq_oe_q, dq_oe_d;
    logic              rise, fall, cs_sync, cs_fall, live, fetch_ok;
    logic [7:0]        out_byte, id_byte;

    assign rise    = sclk_q[1] & ~sclk_q[2];
    assign fall    = ~sclk_q[1] & sclk_q[2];
    assign cs_sync = cs_q[1];
    assign cs_fall = ~cs_q[1] & cs_q[2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        quad_d     = quad_q;
        out_sh_d   = out_sh_q;
        out_cnt_d  = out_cnt_q;
        id_idx_d   = id_idx_q;
        need_d     = need_q;
        buf_d      = buf_q;
        buf_v_d    = buf_v_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_req_q;
        underrun_d = underrun_q;
        dq_o_d     = dq_o_q;
        dq_oe_d    = dq_oe_q;
        out_byte   = 8'hFF;
        sh_next    = quad_q ? {sh_q[19:0], dq_sync_q} : {sh_q[22:0], dq_sync_q[0]};
        live       = (state_q == MODE) || (state_q == DUMMY) || (state_q == DATA);
        case (id_idx_q)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'hFF;
        endcase

        // A late or stale ack (address no longer the one wanted next) is dropped.
        if (mem_req_q && mem_ack) begin
            mem_req_d = 1'b0;
            if (live && mem_addr_q == need_q) begin
                buf_d   = mem_data;
                buf_v_d = 1'b1;
            end
        end

        if (cs_sync) begin
            state_d = IDLE;
            dq_o_d  = 4'h0;
            dq_oe_d = 4'h0;
            buf_v_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) begin
                    state_d   = CMD;
                    cnt_d     = 5'd0;
                    out_cnt_d = 3'd0;
                    id_idx_d  = 2'd0;
                    quad_d    = 1'b0;
                end
                CMD: if (rise) begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        cnt_d = 5'd0;
                        case (sh_next[7:0])
                            8'h03:   state_d = ADDR;
                            8'hEB: begin
                                state_d = ADDR;
                                quad_d  = 1'b1;
                            end
                            8'h9F:   state_d = ID;
                            default: state_d = IGNORE;
                        endcase
                    end
                end
                ADDR: if (rise) begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == (quad_q ? 5'd5 : 5'd23)) begin
                        cnt_d   = 5'd0;
                        need_d  = sh_next[ADDR_W-1:0];
                        state_d = quad_q ? MODE : DATA;
                    end
                end
                MODE: if (rise) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd1) begin
                        cnt_d   = 5'd0;
                        state_d = DUMMY;
                    end
                end
                DUMMY: if (rise) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(DUMMY_QUAD - 1)) begin
                        cnt_d   = 5'd0;
                        state_d = DATA;
                    end
                end
                DATA, ID: if (fall) begin
                    dq_oe_d = quad_q ? 4'hF : 4'h2;
                    if (out_cnt_q == 3'd0) begin
                        if (state_q == ID) begin
                            out_byte = id_byte;
                            if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
                        end else begin
                            need_d = need_q + 1'b1;
                            if (buf_v_d) begin
                                out_byte = buf_d;
                                buf_v_d  = 1'b0;
                            end else begin
                                underrun_d = 1'b1;
                            end
                        end
                        if (quad_q) begin
                            dq_o_d    = out_byte[7:4];
                            out_sh_d  = {out_byte[3:0], 4'h0};
                            out_cnt_d = 3'd1;
                        end else begin
                            dq_o_d    = {2'b00, out_byte[7], 1'b0};
                            out_sh_d  = {out_byte[6:0], 1'b0};
                            out_cnt_d = 3'd7;
                        end
                    end else begin
                        out_cnt_d = out_cnt_q - 3'd1;
                        if (quad_q) begin
                            dq_o_d   = out_sh_q[7:4];
                            out_sh_d = {out_sh_q[3:0], 4'h0};
                        end else begin
                            dq_o_d   = {2'b00, out_sh_q[7], 1'b0};
                            out_sh_d = {out_sh_q[6:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end

        fetch_ok = !cs_sync && ((state_d == MODE) || (state_d == DUMMY) || (state_d == DATA));
        if (fetch_ok && !mem_req_d && !buf_v_d) begin
            mem_req_d  = 1'b1;
            mem_addr_d = need_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q     <= 3'b000;
            cs_q       <= 3'b111;
            dq_meta_q  <= 4'h0;
            dq_sync_q  <= 4'h0;
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            sh_q       <= 24'd0;
            quad_q     <= 1'b0;
            out_sh_q   <= 8'd0;
            out_cnt_q  <= 3'd0;
            id_idx_q   <= 2'd0;
            need_q     <= '0;
            buf_q      <= 8'd0;
            buf_v_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            underrun_q <= 1'b0;
            dq_o_q     <= 4'h0;
            dq_oe_q    <= 4'h0;
        end else begin
            sclk_q     <= {sclk_q[1:0], spi_clk};
            cs_q       <= {cs_q[1:0], spi_cs_n};
            dq_meta_q  <= spi_dq_i;
            dq_sync_q  <= dq_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            quad_q     <= quad_d;
            out_sh_q   <= out_sh_d;
            out_cnt_q  <= out_cnt_d;
            id_idx_q   <= id_idx_d;
            need_q     <= need_d;
            buf_q      <= buf_d;
            buf_v_q    <= buf_v_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            underrun_q <= underrun_d;
            dq_o_q     <= dq_o_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    assign spi_dq_o  = dq_o_q;
    assign spi_dq_oe = dq_oe_q;
    assign mem_addr  = mem_addr_q;
    assign mem_req   = mem_req_q;
    assign underrun  = underrun_q;
endmodule

// File: tb/tb_spiflash4x_target.sv
// Bench for spiflash4x_target: drives the SPI controller side and a memory responder, and
// compares every returned byte with a flash-content model.
module tb_spiflash4x_target;
    logic        clk = 1'b0;
    logic        reset_n, spi_clk, spi_cs_n, mem_ack, mem_req, underrun;
    logic [3:0]  spi_dq_i, spi_dq_o, spi_dq_oe;
    logic [23:0] mem_addr;
    logic [7:0]  mem_data;

    int          tests = 0, fails = 0;
    int          H = 4, ack_delay = 1, mem_mode = 0;
    logic [31:0] mem_seed = 32'd0;
    logic [23:0] fetch_q[$];
    logic [7:0]  got_q[$];
    logic        oe_ok;

    always #5 clk = ~clk;

    spiflash4x_target #(.ADDR_W(24), .JEDEC_ID(24'hEF4016), .DUMMY_QUAD(4)) dut (
        .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_dq_i(spi_dq_i), .spi_dq_o(spi_dq_o), .spi_dq_oe(spi_dq_oe),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
        .underrun(underrun)
    );

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        logic [31:0] h;
        h = ({8'h00, a} * 32'd2654435761) ^ mem_seed;
        case (mem_mode)
            0:       return a[7:0];
            1:       return ~a[7:0];
            default: return h[15:8];
        endcase
    endfunction

    function automatic logic [7:0] model_byte(input logic [7:0] cmd, input logic [23:0] addr, input int k);
        logic [23:0] a;
        a = addr + k[23:0];
        if (cmd == 8'h9F) begin
            case (k)
                0:       return 8'hEF;
                1:       return 8'h40;
                2:       return 8'h16;
                default: return 8'hFF;
            endcase
        end
        return mem_byte(a);
    endfunction

    initial begin
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                fetch_q.push_back(mem_addr);
                repeat (ack_delay - 1) @(negedge clk);
                mem_data = mem_byte(mem_addr);
                mem_ack  = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [3:0] d, input logic [3:0] exp_oe, output logic [3:0] so);
        spi_dq_i = d;
        repeat (H) @(negedge clk);
        so = spi_dq_o;
        if (spi_dq_oe !== exp_oe) oe_ok = 1'b0;
        spi_clk = 1'b1;
        repeat (H) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] so;
        for (int i = 7; i >= 0; i--) tick({3'b000, b[i]}, 4'h0, so);
    endtask

    task automatic send_addr(input logic [23:0] a, input bit quad);
        logic [3:0] so;
        if (quad) for (int i = 5; i >= 0; i--) tick(a[4*i +: 4], 4'h0, so);
        else      for (int i = 23; i >= 0; i--) tick({3'b000, a[i]}, 4'h0, so);
    endtask

    task automatic read_bytes(input bit quad, input logic [3:0] exp_oe, input int n);
        logic [3:0] so;
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            if (quad) begin
                tick(4'h0, exp_oe, so); b[7:4] = so;
                tick(4'h0, exp_oe, so); b[3:0] = so;
            end else begin
                for (int i = 7; i >= 0; i--) begin
                    tick(4'h0, exp_oe, so);
                    b[i] = so[1];
                end
            end
            got_q.push_back(b);
        end
    endtask

    task automatic start_cmd(input logic [7:0] cmd, input logic [23:0] addr);
        logic [3:0] so;
        oe_ok = 1'b1;
        got_q.delete();
        spi_clk  = 1'b0;
        spi_cs_n = 1'b0;
        send_byte(cmd);
        if (cmd == 8'h03) send_addr(addr, 1'b0);
        if (cmd == 8'hEB) begin
            send_addr(addr, 1'b1);
            tick(4'hF, 4'h0, so);
            tick(4'h0, 4'h0, so);
            for (int i = 0; i < 4; i++) tick(4'h0, 4'h0, so);
        end
    endtask

    task automatic cs_end();
        spi_cs_n = 1'b1;
        spi_dq_i = 4'h0;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_read(input string tag, input logic [7:0] cmd, input logic [23:0] addr, input int n);
        logic       known;
        logic [3:0] exp_oe;
        known  = (cmd == 8'h03) || (cmd == 8'hEB) || (cmd == 8'h9F);
        exp_oe = !known ? 4'h0 : (cmd == 8'hEB) ? 4'hF : 4'h2;
        start_cmd(cmd, addr);
        check({tag, "_pre_oe"}, 32'(oe_ok), 32'd1);
        oe_ok = 1'b1;
        read_bytes(cmd == 8'hEB, exp_oe, n);
        cs_end();
        check({tag, "_data_oe"}, 32'(oe_ok), 32'd1);
        if (known)
            for (int k = 0; k < n; k++)
                check($sformatf("%s_b%0d", tag, k), 32'(got_q[k]), 32'(model_byte(cmd, addr, k)));
    endtask

    initial begin
        logic [3:0]  so;
        logic [7:0]  cmd;
        logic [23:0] a;
        reset_n  = 1'b0;
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        spi_dq_i = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_dq_o", 32'(spi_dq_o), 32'h0);
        check("rst_dq_oe", 32'(spi_dq_oe), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        mem_mode = 0;
        run_read("rd03", 8'h03, 24'h000010, 4);
        check("rd03_underrun", 32'(underrun), 32'h0);

        mem_mode = 1;
        run_read("rdEB", 8'hEB, 24'h000100, 4);

        run_read("jedec", 8'h9F, 24'h0, 5);

        mem_mode = 0;
        fetch_q.delete();
        run_read("wrap", 8'h03, 24'hFFFFFF, 2);
        check("wrap_nfetch", 32'(fetch_q.size() >= 2), 32'd1);
        if (fetch_q.size() >= 2) begin
            check("wrap_fetch0", 32'(fetch_q[0]), 32'hFFFFFF);
            check("wrap_fetch1", 32'(fetch_q[1]), 32'h000000);
        end

        H = 4;
        ack_delay = 40;
        mem_mode = 1;
        a = 24'h000345;
        start_cmd(8'hEB, a);
        read_bytes(1'b1, 4'hF, 2);
        cs_end();
        check("late_b0", 32'(got_q[0]), 32'(model_byte(8'hEB, a, 0)));
        check("late_b1", 32'(got_q[1]), 32'hFF);
        check("late_underrun", 32'(underrun), 32'h1);
        repeat (80) @(negedge clk);
        ack_delay = 1;
        run_read("clean", 8'h03, 24'h004321, 3);
        check("clean_underrun_sticky", 32'(underrun), 32'h1);

        oe_ok = 1'b1;
        spi_cs_n = 1'b0;
        send_byte(8'h03);
        for (int i = 0; i < 12; i++) tick(4'h1, 4'h0, so);
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_oe", 32'(spi_dq_oe), 32'h0);
        repeat (6) @(negedge clk);
        run_read("after_abort", 8'h03, 24'h00ABCD, 2);

        mem_mode = 0;
        start_cmd(8'h03, 24'h000200);
        read_bytes(1'b0, 4'h2, 1);
        for (int i = 0; i < 3; i++) tick(4'h0, 4'h2, so);
        check("pre_rst_oe", 32'(spi_dq_oe), 32'h2);
        reset_n = 1'b0;
        #1;
        check("midrst_oe", 32'(spi_dq_oe), 32'h0);
        check("midrst_underrun", 32'(underrun), 32'h0);
        spi_cs_n = 1'b1;
        spi_clk  = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        run_read("post_rst", 8'h03, 24'h000220, 3);

        for (int t = 0; t < 8; t++) begin
            case ($urandom_range(0, 3))
                0:       cmd = 8'h03;
                1:       cmd = 8'hEB;
                2:       cmd = 8'h9F;
                default: cmd = 8'hA5;
            endcase
            H         = $urandom_range(4, 6);
            ack_delay = $urandom_range(1, 3);
            mem_mode  = 2;
            mem_seed  = $urandom;
            a         = 24'($urandom);
            run_read($sformatf("rnd%0d", t), cmd, a, $urandom_range(1, 4));
        end
        check("final_underrun", 32'(underrun), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spiflash4x_target.md
# spiflash4x_target

Synthesizable QSPI flash responder: the device end of the `spiflash4x` bus that the SoC's flash controller drives. Oversamples the serial bus on the system clock, decodes Read (0x03), Quad I/O Fast Read (0xEB) and JEDEC ID (0x9F), and serves data bytes from a byte-wide memory fetch port. Used as a self-contained boot-flash stand-in on FPGA builds and in benches without a vendor flash model.

## Interface
- `ADDR_W`, 24, flash byte-address width; addresses wrap modulo 2^ADDR_W
- `JEDEC_ID`, 24'hEF4016, ID bytes returned by 0x9F, MSB first
- `DUMMY_QUAD`, 4, dummy SPI clocks after the mode byte for 0xEB

- `clk` in 1: system clock; everything is sampled and updated on its rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `spi_clk` in 1: serial clock from the controller, SPI mode 0
- `spi_cs_n` in 1: chip select, active-low
- `spi_dq_i` in 4: dq input; dq[0]=DI, dq[1]=DO, dq[2]=WPn, dq[3]=HOLDn
- `spi_dq_o` out 4: dq output data
- `spi_dq_oe` out 4: per-lane output enable
- `mem_addr` out ADDR_W: byte address to fetch
- `mem_req` out 1: fetch request
- `mem_ack` in 1: fetch complete; `mem_data` is valid in the same cycle
- `mem_data` in 8: fetched byte
- `underrun` out 1: sticky; set when a byte had to be driven before its fetch completed

## Operation
- `spi_clk`, `spi_cs_n` and `spi_dq_i` each pass through a 2-flop synchronizer. Rising and falling `spi_clk` edges are detected from the synchronized value.
- Input bits are sampled on the rising edge. Output bits change after the falling edge.
- FSM states: IDLE, CMD, ADDR, MODE, DUMMY, DATA, ID, IGNORE.
- IDLE: entered whenever synchronized `spi_cs_n`=1. A falling `spi_cs_n` moves the FSM to CMD.
- CMD: shifts 8 bits from dq[0], MSB first.
  - 0x03 → ADDR, single-line (24 clocks).
  - 0xEB → ADDR, quad (6 clocks, dq[3] = MSB of each nibble).
  - 0x9F → ID.
  - Any other opcode → IGNORE.
- ADDR: the low ADDR_W bits of the 24-bit address are captured. On the last address bit, `mem_addr` is loaded and `mem_req` is raised.
  - 0x03 → DATA.
  - 0xEB → MODE.
- MODE: 2 quad clocks; the mode byte value is ignored (continuous-read is not supported). MODE → DUMMY.
- DUMMY: DUMMY_QUAD clocks; dq is not driven. DUMMY → DATA.
- DATA:
  - 0x03: drives dq[1] only, 8 clocks per byte, MSB first.
  - 0xEB: drives all four lanes, 2 clocks per byte, high nibble first.
  - When the first bit of a byte is driven, the next fetch is issued at `mem_addr`+1. This is a one-byte prefetch.
- ID: shifts JEDEC_ID on dq[1]. After 24 bits it drives 0xFF until CS rises.
- IGNORE: drives nothing until CS rises.
- Fetch handshake:
  - `mem_req` stays high until `mem_ack`; it is never dropped early.
  - The acked byte is loaded into the prefetch buffer.
  - If a byte's first bit is due while its fetch is outstanding, that byte is driven as 0xFF and `underrun` is set.
- CS rise mid-transaction: all `spi_dq_oe` go to 0 and the FSM returns to IDLE. An outstanding `mem_req` is held until acked, and that byte is discarded.
- `underrun` clears only on reset.

## Timing
- Reset values:
  - `spi_dq_o`=0, `spi_dq_oe`=0, `mem_req`=0, `mem_addr`=0, `underrun`=0.
  - FSM = IDLE.
- Edge detect latency: 3 `clk` cycles from the pin to the internal edge strobe. Output lanes update at most 4 `clk` after a falling `spi_clk`.
- Constraints on the controller side:
  - `spi_clk` high and low phases ≥ 4 `clk` each.
  - `spi_cs_n` high time ≥ 4 `clk`.
- Output enable:
  - 0x03 / 0x9F: `spi_dq_oe`=4'b0010 from the falling edge after the last command/address bit.
  - 0xEB: 4'b1111 from the falling edge ending DUMMY.
  - Deasserted ≤4 `clk` after CS rises.
- Fetch latency: `mem_ack` must arrive within one byte time, i.e. 8 `spi_clk` periods for 0x03 and 2 for 0xEB.
- The first fetch is issued on the same edge-strobe cycle that captures the final address bit.
- Address increment wraps: 2^ADDR_W−1 → 0.

## Test plan
- 0x03, addr 0x000010, memory[i]=i[7:0] with 1-cycle ack, 4 bytes read → dq[1] carries 0x10,0x11,0x12,0x13; `underrun`=0.
- 0xEB, addr 0x000100, mode 0xF0, 4 dummy clocks, memory[i]=~i[7:0] → nibbles F,F,F,E,F,D…; `spi_dq_oe`=4'hF only during DATA.
- 0x9F → 0xEF,0x40,0x16 on dq[1], then 0xFF.
- Read at addr 0xFFFFFF for 2 bytes → `mem_addr` sequence 0xFFFFFF, 0x000000.
- `mem_ack` delayed 40 `clk` with `spi_clk`=clk/8 on 0xEB → second byte driven 0xFF and `underrun`=1. The flag stays set through the next clean transaction.
- CS raised after 12 address bits, and separately `reset_n` pulsed mid-DATA → `spi_dq_oe`=0 within 4 `clk`. A following 0x03 read returns correct data.
